// File: rtl/ctrl_proc_if.sv
// Command and result handshake bundle between a requester and the ctrl_proc sequencer.
interface ctrl_proc_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RES_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_code;
  logic [DATA_W-1:0] cmd_data;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic [3:0]        res_count;

  modport master (
    output cmd_valid, cmd_code, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_count
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_count
  );
endinterface

// File: rtl/ctrl_proc.sv
// Command sequencer for the accumulator datapath: buffers ADD/SUB/CLR/END commands,
// issues one datapath op per cycle and reports the accumulated result on END.
module ctrl_proc #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RES_W  = 5
) (
  input  logic              clock,
  input  logic              rst_n,
  ctrl_proc_if.slave        bus,
  output logic [DATA_W-1:0] dp_d_in,
  output logic              dp_capture,
  output logic [1:0]        dp_op,
  output logic              dp_clear,
  input  logic [RES_W-1:0]  dp_result,
  output logic              busy
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OPS_W = 4;

  localparam logic [1:0] CODE_ADD = 2'b00;
  localparam logic [1:0] CODE_SUB = 2'b01;
  localparam logic [1:0] CODE_CLR = 2'b10;
  localparam logic [1:0] CODE_END = 2'b11;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b10;

  typedef struct packed {
    logic [1:0]        code;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {RUN, WAIT, REPORT} state_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  state_t           state;
  logic [OPS_W-1:0] op_cnt;
  logic             res_valid_q;
  logic [RES_W-1:0] res_data_q;
  logic [3:0]       res_count_q;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == RUN) && !empty;
  assign head  = mem[rd_ptr];

  assign bus.cmd_ready = !full;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_count = res_count_q;
  assign busy          = (state != RUN) || !empty;

  // Command storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'({bus.cmd_code, bus.cmd_data});
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer: capture/clear pulses last one cycle; op and operand hold when idle.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= RUN;
      op_cnt      <= '0;
      dp_d_in     <= '0;
      dp_capture  <= 1'b0;
      dp_op       <= '0;
      dp_clear    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_count_q <= '0;
    end else begin
      dp_capture <= 1'b0;
      dp_clear   <= 1'b0;
      case (state)
        RUN: begin
          if (!empty) begin
            case (head.code)
              CODE_ADD, CODE_SUB: begin
                dp_capture <= 1'b1;
                dp_op      <= (head.code == CODE_SUB) ? OP_SUB : OP_ADD;
                dp_d_in    <= head.data;
                op_cnt     <= (op_cnt == '1) ? op_cnt : op_cnt + OPS_W'(1);
              end
              CODE_CLR: begin
                dp_clear <= 1'b1;
                op_cnt   <= '0;
              end
              CODE_END: state <= WAIT;
              default:  state <= RUN;
            endcase
          end
        end
        // One spare cycle lets the final capture/clear settle into dp_result.
        WAIT: begin
          res_data_q  <= dp_result;
          res_count_q <= op_cnt;
          res_valid_q <= 1'b1;
          state       <= REPORT;
        end
        REPORT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            op_cnt      <= '0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
